// File: rtl/wait_control_if.sv
`default_nettype none
// ============================================================================
//  Module   : wait_control_if
//  Purpose  : Bundles the decoder-side inputs and the datapath strobes of the
//             wait_control instruction sequencer. The controller uses the
//             master modport. A datapath or bench model uses the slave modport.
//  Revision : 1.0 - initial release
// ============================================================================
interface wait_control_if #(
  parameter int ICNT_W = 16
);
  // Opcode encoding: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
  logic [2:0]        opcode;
  logic              zero;
  logic              mem_ready;
  logic              resume;

  logic              load_ac;
  logic              mem_rd;
  logic              mem_wr;
  logic              inc_pc;
  logic              load_pc;
  logic              load_ir;
  logic              halt;
  logic              mem_err;
  logic [3:0]        phase;
  logic [ICNT_W-1:0] instr_cnt;

  modport master (
    input  opcode, zero, mem_ready, resume,
    output load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt,
           mem_err, phase, instr_cnt
  );

  modport slave (
    output opcode, zero, mem_ready, resume,
    input  load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt,
           mem_err, phase, instr_cnt
  );
endinterface
`default_nettype wire

// File: rtl/wait_control.sv
`default_nettype none
// ============================================================================
//  Module   : wait_control
//  Purpose  : 8-phase VeriRISC instruction sequencer with memory wait states
//             (mem_ready handshake), a wait-timeout error trap, a resumable
//             halt and a retired-instruction counter.
//  Revision : 1.0 - initial release
// ============================================================================
module wait_control #(
  parameter int TIMEOUT   = 15,
  parameter int ZERO_WAIT = 0,
  parameter int ICNT_W    = 16
) (
  input  wire logic      clk,
  input  wire logic      rst_,
  wait_control_if.master bus
);

  // A TIMEOUT of 0 disables the trap, but the counter still needs one bit.
  localparam int WCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] c_op_hlt = 3'd0;
  localparam logic [2:0] c_op_skz = 3'd1;
  localparam logic [2:0] c_op_add = 3'd2;
  localparam logic [2:0] c_op_and = 3'd3;
  localparam logic [2:0] c_op_xor = 3'd4;
  localparam logic [2:0] c_op_lda = 3'd5;
  localparam logic [2:0] c_op_sto = 3'd6;
  localparam logic [2:0] c_op_jmp = 3'd7;

  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8,
    S_ERROR      = 4'd9
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [ICNT_W-1:0]   r_icnt;

  logic w_ready;
  logic w_aluop;
  logic w_is_hlt;
  logic w_is_skz;
  logic w_is_sto;
  logic w_is_jmp;
  logic w_waiting;
  logic w_stall;
  logic w_timeout;
  logic w_retire;

  logic w_load_ac;
  logic w_mem_rd;
  logic w_mem_wr;
  logic w_inc_pc;
  logic w_load_pc;
  logic w_load_ir;
  logic w_halt;
  logic w_mem_err;

  // In legacy zero-wait mode memory is always considered ready.
  assign w_ready  = (ZERO_WAIT != 0) ? 1'b1 : bus.mem_ready;

  assign w_aluop  = (bus.opcode == c_op_add) || (bus.opcode == c_op_and) ||
                    (bus.opcode == c_op_xor) || (bus.opcode == c_op_lda);
  assign w_is_hlt = (bus.opcode == c_op_hlt);
  assign w_is_skz = (bus.opcode == c_op_skz);
  assign w_is_sto = (bus.opcode == c_op_sto);
  assign w_is_jmp = (bus.opcode == c_op_jmp);

  // Phases that hold on mem_ready: instruction load always, ALU_OP only for
  // memory-reading opcodes, STORE only for the write.
  always_comb begin
    w_waiting = 1'b0;
    case (r_state)
      S_INST_LOAD: w_waiting = 1'b1;
      S_ALU_OP:    w_waiting = w_aluop;
      S_STORE:     w_waiting = w_is_sto;
      default:     w_waiting = 1'b0;
    endcase
  end

  assign w_stall   = w_waiting && !w_ready;
  // mem_ready arriving in the limit cycle wins because w_stall is then low.
  assign w_timeout = (TIMEOUT != 0) && w_stall &&
                     (r_wcnt == WCNT_W'(TIMEOUT));
  assign w_retire  = (r_state == S_STORE) && (w_next == S_INST_ADDR);

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INST_ADDR:  w_next = S_INST_FETCH;
      S_INST_FETCH: w_next = S_INST_LOAD;
      S_INST_LOAD: begin
        if (w_ready)        w_next = S_IDLE;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_IDLE:       w_next = S_OP_ADDR;
      S_OP_ADDR:    w_next = w_is_hlt ? S_HALTED : S_OP_FETCH;
      S_OP_FETCH:   w_next = S_ALU_OP;
      S_ALU_OP: begin
        if (!w_aluop || w_ready) w_next = S_STORE;
        else if (w_timeout)      w_next = S_ERROR;
      end
      S_STORE: begin
        if (!w_is_sto || w_ready) w_next = S_INST_ADDR;
        else if (w_timeout)       w_next = S_ERROR;
      end
      S_HALTED:     w_next = bus.resume ? S_INST_ADDR : S_HALTED;
      S_ERROR:      w_next = S_ERROR;
      default:      w_next = S_INST_ADDR;
    endcase
  end

  // Datapath strobes decoded from the current phase and opcode.
  always_comb begin
    w_load_ac = 1'b0;
    w_mem_rd  = 1'b0;
    w_mem_wr  = 1'b0;
    w_inc_pc  = 1'b0;
    w_load_pc = 1'b0;
    w_load_ir = 1'b0;
    w_halt    = 1'b0;
    w_mem_err = 1'b0;
    case (r_state)
      S_INST_FETCH: w_mem_rd = 1'b1;
      S_INST_LOAD: begin
        w_mem_rd  = 1'b1;
        w_load_ir = w_ready;
      end
      S_IDLE: begin
        w_mem_rd  = 1'b1;
        w_load_ir = 1'b1;
      end
      S_OP_ADDR: begin
        w_inc_pc = 1'b1;
        w_halt   = w_is_hlt;
      end
      S_OP_FETCH:   w_mem_rd = w_aluop;
      S_ALU_OP: begin
        w_mem_rd  = w_aluop;
        w_load_ac = w_aluop && w_ready;
        w_inc_pc  = w_is_skz && bus.zero;
        w_load_pc = w_is_jmp;
      end
      S_STORE: begin
        w_mem_rd  = w_aluop;
        w_load_ac = w_aluop;
        w_inc_pc  = w_is_jmp;
        w_load_pc = w_is_jmp;
        w_mem_wr  = w_is_sto;
      end
      S_HALTED:     w_halt = 1'b1;
      S_ERROR: begin
        w_halt    = 1'b1;
        w_mem_err = 1'b1;
      end
      default: ;
    endcase
  end

  // Phase register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= S_INST_ADDR;
    else       r_state <= w_next;
  end

  // Consecutive not-ready counter, restarted whenever the phase changes.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                  r_wcnt <= '0;
    else if (w_next != r_state) r_wcnt <= '0;
    else if (w_stall)           r_wcnt <= r_wcnt + 1'b1;
  end

  // Retired-instruction counter, bumped as STORE hands back to INST_ADDR.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)         r_icnt <= '0;
    else if (w_retire) r_icnt <= r_icnt + 1'b1;
  end

  assign bus.load_ac   = w_load_ac;
  assign bus.mem_rd    = w_mem_rd;
  assign bus.mem_wr    = w_mem_wr;
  assign bus.inc_pc    = w_inc_pc;
  assign bus.load_pc   = w_load_pc;
  assign bus.load_ir   = w_load_ir;
  assign bus.halt      = w_halt;
  assign bus.mem_err   = w_mem_err;
  assign bus.phase     = r_state;
  assign bus.instr_cnt = r_icnt;

endmodule
`default_nettype wire
